// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and types for the data memory responder.
//                Contains the funct3 access-size codes, the FSM state type
//                and a funct3 legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Stores accept only the signed size codes; loads also accept BU/HU.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational lane steering. Merges store data into the old
//                word, extracts and extends load data, and flags misaligned
//                halfword/word accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] store_word,
    output logic [31:0] load_word,
    output logic        misalign
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/halfword and build both load and store views.
    always_comb begin
        byte_shift = {lane, 3'b000};
        half_shift = {lane[1], 4'b0000};
        sel_byte   = 8'(old_word >> byte_shift);
        sel_half   = 16'(old_word >> half_shift);
        load_word  = old_word;
        store_word = old_word;
        misalign   = 1'b0;
        case (funct3)
            F3_B: begin
                load_word  = {{24{sel_byte[7]}}, sel_byte};
                store_word = (old_word & ~(32'h0000_00FF << byte_shift))
                           | ({24'd0, wdata[7:0]} << byte_shift);
            end
            F3_BU: begin
                load_word = {24'd0, sel_byte};
            end
            F3_H: begin
                load_word  = {{16{sel_half[15]}}, sel_half};
                store_word = (old_word & ~(32'h0000_FFFF << half_shift))
                           | ({16'd0, wdata[15:0]} << half_shift);
                misalign   = lane[0];
            end
            F3_HU: begin
                load_word = {16'd0, sel_half};
                misalign  = lane[0];
            end
            F3_W: begin
                load_word  = old_word;
                store_word = wdata;
                misalign   = (lane != 2'b00);
            end
            default: begin
                load_word = old_word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data-port responder for the multicycle core. Accepts a
//                one-cycle load/store strobe, waits WAIT_STATES cycles,
//                accesses the word array and returns a one-cycle response
//                with lane-steered load data or an error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [31:0]   store_word;
    logic [31:0]   load_word;
    logic          misalign;
    logic          out_of_range;
    logic          access;
    logic          err;

    assign word_idx     = addr_q[2 +: AW];
    assign old_word     = mem[word_idx];
    assign out_of_range = (addr_q >> (AW + 2)) != 32'd0;
    assign access       = (state == ST_WAIT) && (wait_cnt == 4'd0);
    assign err          = (rd_q && wr_q) || out_of_range || misalign
                        || !funct3_legal(funct3_q, wr_q);

    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    mem_lane_align u_align (
        .old_word   (old_word),
        .wdata      (wdata_q),
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .store_word (store_word),
        .load_word  (load_word),
        .misalign   (misalign)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, hold in WAIT until the counter drains, one RESP cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_read || req_write) state_next = ST_WAIT;
            ST_WAIT: if (access) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture and wait-state countdown; strobes outside IDLE are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else if (state == ST_IDLE && (req_read || req_write)) begin
            wait_cnt <= 4'(WAIT_STATES);
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            rd_q     <= req_read;
            wr_q     <= req_write;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Response registers load on the access edge and hold until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (access) begin
            resp_err   <= err;
            resp_rdata <= (err || !rd_q) ? 32'd0 : load_word;
        end
    end

    // Array write; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (access && wr_q && !err) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. Three instances
//                (WAIT_STATES 2, 0, 3) share a request bus gated per instance,
//                and a byte-level memory model predicts every response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic        e;
        logic [31:0] r;
    } op_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [2:0]  sel = 3'b111;

    logic [2:0]       rd_g, wr_g, vld, err_o, bsy;
    logic [2:0][31:0] rdat;

    assign rd_g = sel & {3{req_read}};
    assign wr_g = sel & {3{req_write}};

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut (
        .clk(clk), .resetn(resetn), .req_read(rd_g[0]), .req_write(wr_g[0]),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(vld[0]), .resp_rdata(rdat[0]), .resp_err(err_o[0]), .busy(bsy[0]));

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .resetn(resetn), .req_read(rd_g[1]), .req_write(wr_g[1]),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(vld[1]), .resp_rdata(rdat[1]), .resp_err(err_o[1]), .busy(bsy[1]));

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .resetn(resetn), .req_read(rd_g[2]), .req_write(wr_g[2]),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(vld[2]), .resp_rdata(rdat[2]), .resp_err(err_o[2]), .busy(bsy[2]));

    logic [31:0] mdl [3][DEPTH];
    int          lat [3];
    int          npulse [3];
    logic [31:0] got_rdata [3];
    logic        got_err [3];
    logic [31:0] exp_rdata [3];
    logic        exp_err [3];
    int          passed = 0;
    int          total = 0;

    function automatic int ws_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // Reference model: byte-addressed view of each instance's memory.
    function automatic void model(input int k, input logic rd, input logic wr,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] f3,
                                  output logic e, output logic [31:0] r);
        int          n;
        int          idx;
        int          lane;
        logic [31:0] v;
        logic [31:0] m;
        n    = 1 << f3[1:0];
        idx  = int'(a >> 2);
        lane = int'(a % 4);
        e    = 1'b0;
        r    = 32'd0;
        if (rd && wr) e = 1'b1;
        if (a >= 32'(4 * DEPTH)) e = 1'b1;
        if (f3[1:0] == 2'd1 && (a % 2) != 0) e = 1'b1;
        if (f3[1:0] == 2'd2 && lane != 0) e = 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) e = 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
        if (!e && wr) begin
            for (int i = 0; i < n; i++) begin
                mdl[k][idx][8*(lane+i) +: 8] = wd[8*i +: 8];
            end
        end
        if (!e && rd) begin
            v = mdl[k][idx] >> (8 * lane);
            if (n < 4) begin
                m = (32'd1 << (8 * n)) - 32'd1;
                v = v & m;
                if (!f3[2] && v[8*n-1]) v = v | ~m;
            end
            r = v;
        end
    endfunction

    // Issue one request to the selected instances and record responses for 12 cycles.
    task automatic run_req(input logic [2:0] s, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        for (int k = 0; k < 3; k++) begin
            if (s[k]) model(k, rd, wr, a, wd, f3, exp_err[k], exp_rdata[k]);
            lat[k]       = -1;
            npulse[k]    = 0;
            got_rdata[k] = 'x;
            got_err[k]   = 1'bx;
        end
        @(negedge clk);
        sel        = s;
        req_read   = rd;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    npulse[k]++;
                    if (lat[k] < 0) begin
                        lat[k]       = c;
                        got_rdata[k] = rdat[k];
                        got_err[k]   = err_o[k];
                    end
                end
            end
            if (c == 1) begin
                req_read  = 1'b0;
                req_write = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (vld[k] !== 1'b0 || bsy[k] !== 1'b0 || err_o[k] !== 1'b0 || rdat[k] !== 32'd0)
                $display("FAIL reset_state dut%0d: valid %b busy %b err %b rdata %08h, expected all 0",
                         k, vld[k], bsy[k], err_o[k], rdat[k]);
            else passed++;
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic init_memory();
        for (int w = 0; w < DEPTH; w++) begin
            run_req(3'b111, 1'b0, 1'b1, 32'(4 * w), $urandom, 3'b010);
        end
    endtask

    task automatic test_word_roundtrip();
        op_t ops [2];
        ops[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0};
        ops[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
        for (int i = 0; i < 2; i++) begin
            run_req(3'b111, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ops[i].f3);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (lat[k] != ws_of(k) + 2 || npulse[k] != 1 || got_err[k] !== ops[i].e || got_rdata[k] !== ops[i].r)
                    $display("FAIL word_roundtrip op%0d dut%0d: cycle %0d pulses %0d err %b rdata %08h, expected cycle %0d pulses 1 err %b rdata %08h",
                             i, k, lat[k], npulse[k], got_err[k], got_rdata[k], ws_of(k) + 2, ops[i].e, ops[i].r);
                else passed++;
            end
        end
    endtask

    task automatic test_byte_lanes();
        op_t ops [4];
        ops[0] = '{1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, 1'b0, 32'h0};
        ops[1] = '{1'b1, 1'b0, 32'h13, 32'h0,        3'b000, 1'b0, 32'hFFFFFF80};
        ops[2] = '{1'b1, 1'b0, 32'h13, 32'h0,        3'b100, 1'b0, 32'h00000080};
        ops[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 32'h80ADBEEF};
        for (int i = 0; i < 4; i++) begin
            run_req(3'b111, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ops[i].f3);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (lat[k] != ws_of(k) + 2 || npulse[k] != 1 || got_err[k] !== ops[i].e || got_rdata[k] !== ops[i].r)
                    $display("FAIL byte_lanes op%0d dut%0d: cycle %0d pulses %0d err %b rdata %08h, expected cycle %0d pulses 1 err %b rdata %08h",
                             i, k, lat[k], npulse[k], got_err[k], got_rdata[k], ws_of(k) + 2, ops[i].e, ops[i].r);
                else passed++;
            end
        end
    endtask

    task automatic test_halfword();
        op_t ops [4];
        ops[0] = '{1'b0, 1'b1, 32'h12, 32'h00008001, 3'b001, 1'b0, 32'h0};
        ops[1] = '{1'b1, 1'b0, 32'h12, 32'h0,        3'b001, 1'b0, 32'hFFFF8001};
        ops[2] = '{1'b1, 1'b0, 32'h12, 32'h0,        3'b101, 1'b0, 32'h00008001};
        ops[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 1'b0, 32'h8001BEEF};
        for (int i = 0; i < 4; i++) begin
            run_req(3'b111, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ops[i].f3);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (lat[k] != ws_of(k) + 2 || npulse[k] != 1 || got_err[k] !== ops[i].e || got_rdata[k] !== ops[i].r)
                    $display("FAIL halfword op%0d dut%0d: cycle %0d pulses %0d err %b rdata %08h, expected cycle %0d pulses 1 err %b rdata %08h",
                             i, k, lat[k], npulse[k], got_err[k], got_rdata[k], ws_of(k) + 2, ops[i].e, ops[i].r);
                else passed++;
            end
        end
    endtask

    task automatic test_errors();
        op_t ops [10];
        ops[0] = '{1'b0, 1'b1, 32'h11,            32'h0000AAAA, 3'b001, 1'b1, 32'h0};
        ops[1] = '{1'b1, 1'b0, 32'h10,            32'h0,        3'b010, 1'b0, 32'h8001BEEF};
        ops[2] = '{1'b1, 1'b0, 32'h12,            32'h0,        3'b010, 1'b1, 32'h0};
        ops[3] = '{1'b1, 1'b1, 32'h10,            32'h55555555, 3'b010, 1'b1, 32'h0};
        ops[4] = '{1'b1, 1'b0, 32'h10,            32'h0,        3'b010, 1'b0, 32'h8001BEEF};
        ops[5] = '{1'b1, 1'b0, 32'(4 * DEPTH),    32'h0,        3'b010, 1'b1, 32'h0};
        ops[6] = '{1'b1, 1'b0, 32'h10,            32'h0,        3'b011, 1'b1, 32'h0};
        ops[7] = '{1'b0, 1'b1, 32'h10,            32'h12345678, 3'b100, 1'b1, 32'h0};
        ops[8] = '{1'b1, 1'b0, 32'h10,            32'h0,        3'b010, 1'b0, 32'h8001BEEF};
        ops[9] = '{1'b1, 1'b0, 32'(4 * DEPTH - 2), 32'h0,       3'b101, 1'b0, 32'h0};
        ops[9].r = {16'd0, mdl[0][DEPTH-1][31:16]};
        for (int i = 0; i < 10; i++) begin
            run_req(3'b111, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ops[i].f3);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (lat[k] != ws_of(k) + 2 || npulse[k] != 1 || got_err[k] !== ops[i].e || got_rdata[k] !== ops[i].r)
                    $display("FAIL errors op%0d dut%0d: cycle %0d pulses %0d err %b rdata %08h, expected cycle %0d pulses 1 err %b rdata %08h",
                             i, k, lat[k], npulse[k], got_err[k], got_rdata[k], ws_of(k) + 2, ops[i].e, ops[i].r);
                else passed++;
            end
        end
    endtask

    task automatic test_busy_drop();
        logic        e;
        logic [31:0] r;
        int          n;
        int          first;
        logic [31:0] seen;
        model(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, e, r);
        n = 0; first = -1; seen = 'x;
        @(negedge clk);
        sel = 3'b001; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (vld[0]) begin
                n++;
                if (first < 0) begin first = c; seen = rdat[0]; end
            end
            if (c == 1) req_read = 1'b0;
            if (c == 2) begin req_read = 1'b1; req_addr = 32'h14; end
            if (c == 3) req_read = 1'b0;
        end
        total++;
        if (n != 1 || first != 4 || seen !== r)
            $display("FAIL busy_drop: pulses %0d cycle %0d rdata %08h, expected pulses 1 cycle 4 rdata %08h",
                     n, first, seen, r);
        else passed++;
    endtask

    task automatic test_reset_abort();
        run_req(3'b001, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        @(negedge clk);
        sel = 3'b001; req_write = 1'b1; req_read = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        total++;
        if (bsy[0] !== 1'b1) $display("FAIL abort_busy_before: busy %b, expected 1", bsy[0]);
        else passed++;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (vld[0] !== 1'b0 || bsy[0] !== 1'b0 || err_o[0] !== 1'b0 || rdat[0] !== 32'd0)
            $display("FAIL abort_outputs: valid %b busy %b err %b rdata %08h, expected all 0",
                     vld[0], bsy[0], err_o[0], rdat[0]);
        else passed++;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        run_req(3'b001, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        total++;
        if (lat[0] != 4 || got_err[0] !== 1'b0 || got_rdata[0] !== exp_rdata[0])
            $display("FAIL abort_no_write: cycle %0d err %b rdata %08h, expected cycle 4 err 0 rdata %08h",
                     lat[0], got_err[0], got_rdata[0], exp_rdata[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            logic        e1, e2;
            logic [31:0] r1, r2, s1, s2;
            int          n, c1, c2, ws;
            logic        busy_seen;
            ws = ws_of(k);
            model(k, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, e1, r1);
            model(k, 1'b1, 1'b0, 32'h14, 32'h0, 3'b010, e2, r2);
            n = 0; c1 = -1; c2 = -1; s1 = 'x; s2 = 'x; busy_seen = 1'b0;
            @(negedge clk);
            sel = 3'(1 << k); req_read = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
            for (int c = 1; c <= 2 * ws + 9; c++) begin
                @(posedge clk);
                #1;
                if (vld[k]) begin
                    n++;
                    if (n == 1) begin c1 = c; s1 = rdat[k]; end
                    if (n == 2) begin c2 = c; s2 = rdat[k]; end
                end
                if (c == ws + 4) busy_seen = bsy[k];
                if (c == 1) req_read = 1'b0;
                if (c == ws + 3) begin req_read = 1'b1; req_addr = 32'h14; end
                if (c == ws + 4) req_read = 1'b0;
            end
            total++;
            if (n != 2 || c1 != ws + 2 || c2 != 2 * ws + 5 || s1 !== r1 || s2 !== r2 || busy_seen !== 1'b1)
                $display("FAIL back_to_back dut%0d: pulses %0d cycles %0d,%0d rdata %08h,%08h busy %b, expected pulses 2 cycles %0d,%0d rdata %08h,%08h busy 1",
                         k, n, c1, c2, s1, s2, busy_seen, ws + 2, 2 * ws + 5, r1, r2);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 19);
            rd = (kind < 9) || (kind >= 18);
            wr = (kind >= 9);
            if ($urandom_range(0, 7) != 0) begin
                if (wr && !rd) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0:       f3 = 3'b000;
                        1:       f3 = 3'b001;
                        2:       f3 = 3'b010;
                        3:       f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = 32'($urandom_range(0, 4 * DEPTH - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
            run_req(3'b111, rd, wr, a, $urandom, f3);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (lat[k] != ws_of(k) + 2 || npulse[k] != 1 || got_err[k] !== exp_err[k] || got_rdata[k] !== exp_rdata[k])
                    $display("FAIL random op%0d dut%0d (rd %b wr %b addr %08h f3 %03b): cycle %0d pulses %0d err %b rdata %08h, expected cycle %0d pulses 1 err %b rdata %08h",
                             i, k, rd, wr, a, f3, lat[k], npulse[k], got_err[k], got_rdata[k],
                             ws_of(k) + 2, exp_err[k], exp_rdata[k]);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        init_memory();
        test_word_roundtrip();
        test_byte_lanes();
        test_halfword();
        test_errors();
        test_busy_drop();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the multicycle RISC-V core's data port. Samples the single-cycle `mem_read` / `mem_write` strobes issued by the control unit, services them against an internal word-organised data memory after a programmable number of wait states, and returns one response pulse with load data or an error flag. Handles byte/half/word lane steering, sign/zero extension and alignment/range checking, so the datapath sees a clean 32-bit value.

## Interface
Parameters:
- `DEPTH`, 1024: data memory size in 32-bit words; power of two.
- `WAIT_STATES`, 2: extra cycles between request acceptance and access; 0–15.

Ports:
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `req_read`  in  1  load request strobe (control unit `mem_read`).
- `req_write`  in  1  store request strobe (control unit `mem_write`).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_funct3`  in  3  access size: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use SB 000, SH 001, SW 010.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  request rejected; qualified by `resp_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `req_read | req_write`, latch addr/wdata/funct3/kind, load wait counter with `WAIT_STATES`, go WAIT. Otherwise stay.
- WAIT: if counter ≠ 0, decrement and stay. If counter = 0, perform access at this edge, register response, go RESP.
- RESP: `resp_valid`=1 for exactly this cycle, go IDLE.
- Requests arriving in WAIT or RESP are dropped silently; the requester must not issue while `busy`.
- Error conditions: any error gives `resp_err`=1, `resp_rdata`=0, and no array write.
  - `req_read` and `req_write` both high.
  - Address ≥ 4·DEPTH.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - funct3 not in the load list (loads) or not in {000,001,010} (stores).
- Word index is addr[2 +: log2(DEPTH)]; lane is addr[1:0].
- Loads:
  - LB: sign-extends byte lane addr[1:0]; LBU zero-extends it.
  - LH / LHU: use halfword addr[1], sign- / zero-extended.
  - LW: full word.
- Stores:
  - SB writes only the addressed byte with wdata[7:0].
  - SH writes only the addressed halfword with wdata[15:0].
  - SW writes the full word.
  - Other lanes are preserved.
- `resp_rdata` / `resp_err` hold their last value until the next RESP; they are meaningful only with `resp_valid`.

## Timing
- Request sampled in cycle 0 (IDLE). WAIT occupies cycles 1..WAIT_STATES+1. Access occurs at the end of cycle WAIT_STATES+1. `resp_valid` is high in cycle WAIT_STATES+2.
- Back-to-back: the earliest next accept is cycle WAIT_STATES+3 (IDLE), so throughput is one access per WAIT_STATES+3 cycles.
- Reset (async, any time):
  - State → IDLE; counter, `resp_valid`, `resp_rdata`, `resp_err` and `busy` → 0.
  - A store aborted before its access edge never writes.
  - Array contents are not reset.
- Read-after-write to the same word in consecutive requests returns the new data.

## Structure
- Package `mem_pkg`: funct3 size constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum.
- Sub-module `mem_lane_align`: purely combinational. Takes old word, wdata, funct3 and lane; outputs the merged store word, the extracted/extended load word, and the misalign flag.
- Top level holds the FSM, wait counter, request latches and array.

## Test plan
- **Word round-trip:** WAIT_STATES=2, SW 0xDEADBEEF @0x10, then LW @0x10 → `resp_valid` in cycle 4 after each request, `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- **Byte store/load:** after the above, SB 0x80 @0x13 → LB @0x13 = 0xFFFFFF80, LBU @0x13 = 0x00000080, LW @0x10 = 0x80ADBEEF.
- **Halfword extension:** SH 0x8001 @0x12 → LH @0x12 = 0xFFFF8001, LHU @0x12 = 0x00008001, LW @0x10 = 0x8001BEEF.
- **Errors:** each of the following gives `resp_err`=1, `resp_rdata`=0, and memory @0x10 unchanged:
  - SH @0x11.
  - LW @0x12.
  - Read+write both high.
  - LW @4·DEPTH.
  - funct3=011 load.
- **Busy drop and reset abort:**
  - A new `req_read` during WAIT is ignored: exactly one `resp_valid`.
  - `resetn` low mid-WAIT of SW 0x12345678 @0x20 → all outputs 0 immediately; a later LW @0x20 returns the prior value.
- **Latency sweep:** WAIT_STATES=0 gives `resp_valid` in cycle 2; WAIT_STATES=3 gives cycle 5. Back-to-back requests are accepted in the cycle right after RESP.
